hilo_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers of the MIPS core. It takes MULT/MULTU/DIV/DIVU requests from decode, runs an iterative 32-step shift-add or restoring-divide sequence, and commits the results to HI/LO. It also services MTHI/MTLO writes. It exposes `busy`, which the pipeline uses to stall MFHI/MFLO and new mul/div issue. The combinational ALU stops computing HI/LO itself.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/hilo_muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mul/div op encoding, funct decode, HI/LO unit state.
package mips_pkg;

  localparam int unsigned MD_OP_W = 2;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 2'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 2'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 2'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 2'd3;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_t;

  // True when the funct field selects one of the mul/div instructions.
  function automatic logic md_is_muldiv_funct(input logic [5:0] funct);
    return (funct >= FUNCT_MULT) && (funct <= FUNCT_DIVU);
  endfunction

  // Funct-to-op mapping used by decode; only meaningful when md_is_muldiv_funct.
  function automatic logic [MD_OP_W-1:0] md_funct_to_op(input logic [5:0] funct);
    logic [MD_OP_W-1:0] op;
    unique case (funct)
      FUNCT_MULT:  op = MD_MULT;
      FUNCT_MULTU: op = MD_MULTU;
      FUNCT_DIV:   op = MD_DIV;
      default:     op = MD_DIVU;
    endcase
    return op;
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  md_state_t          state, state_n;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      acc;
  logic [WIDTH-1:0]   opnd;
  logic [1:0]         op_q;
  logic               q_neg, r_neg;
  logic               busy_n, done_n;

  // Operand magnitudes and result signs captured at issue.
  logic               a_neg_c, b_neg_c;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c;

  // One iteration of the multiply or restoring-divide datapath.
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH:0]     div_trial_c;
  logic [WIDTH-1:0]   div_diff_c;
  logic               div_ge_c;
  logic [AW-1:0]      acc_step_c;

  // Sign-corrected results applied at commit.
  logic [AW-1:0]      prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

  // Absolute values of the incoming operands for signed ops.
  always_comb begin
    a_neg_c = md_is_signed(op) & rs_val[WIDTH-1];
    b_neg_c = md_is_signed(op) & rt_val[WIDTH-1];
    a_mag_c = a_neg_c ? (~rs_val + WIDTH'(1)) : rs_val;
    b_mag_c = b_neg_c ? (~rt_val + WIDTH'(1)) : rt_val;
  end

  // Shift-add multiply step and restoring shift-subtract divide step.
  always_comb begin
    mul_sum_c   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
    div_trial_c = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    div_ge_c    = div_trial_c >= {1'b0, opnd};
    div_diff_c  = div_trial_c[WIDTH-1:0] - opnd;
    if (md_is_div(op_q)) begin
      acc_step_c = {(div_ge_c ? div_diff_c : div_trial_c[WIDTH-1:0]),
                    acc[WIDTH-2:0], div_ge_c};
    end else begin
      acc_step_c = {mul_sum_c, acc[WIDTH-1:1]};
    end
  end

  // Two's-complement fixup of magnitude results.
  always_comb begin
    prod_fix_c = q_neg ? (~acc + AW'(1)) : acc;
    quo_fix_c  = q_neg ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_fix_c  = r_neg ? (~acc[AW-1:WIDTH] + WIDTH'(1)) : acc[AW-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      MD_IDLE:  if (start) state_n = MD_CALC;
      MD_CALC:  if (cnt == CW'(WIDTH - 1)) state_n = MD_FIXUP;
      MD_FIXUP: state_n = MD_IDLE;
      default:  state_n = MD_IDLE;
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    busy_n = 1'b0;
    done_n = 1'b0;
    busy_n = (state_n != MD_IDLE);
    done_n = (state == MD_FIXUP);
  end

  // Status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_n;
      done <= done_n;
    end
  end

  // Operand capture, iteration, commit and MTHI/MTLO writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      op_q  <= MD_MULT;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            op_q  <= op;
            q_neg <= a_neg_c ^ b_neg_c;
            r_neg <= a_neg_c;
            cnt   <= '0;
            if (md_is_div(op)) begin
              acc  <= {WIDTH'(0), a_mag_c};
              opnd <= b_mag_c;
            end else begin
              acc  <= {WIDTH'(0), b_mag_c};
              opnd <= a_mag_c;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MD_CALC: begin
          acc <= acc_step_c;
          cnt <= cnt + CW'(1);
        end
        MD_FIXUP: begin
          if (md_is_div(op_q)) begin
            hi <= rem_fix_c;
            lo <= quo_fix_c;
          end else begin
            hi <= prod_fix_c[AW-1:WIDTH];
            lo <= prod_fix_c[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit with a cycle-level reference model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Architectural result of a mul/div op as {HI, LO}.
  function automatic logic [63:0] md_result(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] am, bm, q, r;
    logic        sa, sb;
    case (o)
      2'd0: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        sa = (o == 2'd2) && a[31];
        sb = (o == 2'd2) && b[31];
        am = sa ? -a : a;
        bm = sb ? -b : b;
        if (bm == 0) begin
          q = 32'hFFFF_FFFF;
          r = am;
        end else begin
          q = am / bm;
          r = am % bm;
        end
        if (sa ^ sb) q = -q;
        if (sa) r = -r;
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  // Reference model: issue, 33-cycle latency, commit, MT writes while idle.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        m_pend = md_result(op, rs_val, rt_val);
        m_left = 33;
        m_busy = 1'b1;
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (done === 1'b1) done_seen++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(o, a, b);
    wait_done(n);
    chk({name, "_latency"}, 32'(n), 32'd33);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back issue: each new start lands in the previous done cycle.
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_z",    2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div_z_neg", 2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001);
    run_op("divu_7",    2'd3, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("mult_mix",  2'd0, 32'd1000,      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FC18);

    // MTHI alone, then both together.
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    step();
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hAAAA_5555);
    chk("mthi_lo", lo, 32'hFFFF_FC18);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'd0;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'd0);
    chk("mt_both_lo", lo, 32'd0);

    // start wins over a same-cycle MTLO.
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    run_op("start_wins", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6);
    lo_we = 1'b0;
    step();

    // Start and MTHI while busy are both ignored.
    issue(2'd1, 32'd3, 32'd5);
    repeat (9) step();
    start = 1'b1; op = 2'd2; rs_val = 32'd77; rt_val = 32'd7;
    hi_we = 1'b1; wdata = 32'h1234;
    step();
    start = 1'b0; hi_we = 1'b0;
    chk("busy_hold_hi", hi, 32'd0);
    wait_done(n);
    chk("overlap_latency", 32'(n), 32'd23);
    chk("overlap_hi", hi, 32'd0);
    chk("overlap_lo", lo, 32'd15);
    step();

    // Reset mid-operation aborts without a commit.
    issue(2'd0, 32'd7, 32'd9);
    repeat (5) step();
    done_seen = 0;
    rst_n = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    rst_n = 1'b1;
    repeat (40) step();
    chk("abort_no_done", 32'(done_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
